minmax_stretch_ctrl: RTL

//  Per-frame controller for the min/max contrast-stretch datapath. It measures the pixel

---
 rtl/minmax_stretch_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/minmax_stretch_ctrl.sv
// Per-frame min/max statistics plus bit-serial gain divider for the contrast-stretch stage.
// Optional temporal smoothing of min/max is enabled with `define MINMAX_IIR_EN.
module minmax_stretch_ctrl #(
  parameter int DATA_WIDTH = 13,
  parameter int GAIN_FRAC  = 16,
  parameter int GAIN_WIDTH = 24,
  parameter int IIR_SHIFT  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fval_in,
  input  logic                  lval_in,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] min_val,
  output logic [DATA_WIDTH-1:0] max_val,
  output logic [GAIN_WIDTH-1:0] gain,
  output logic                  cfg_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int QB = 8 + GAIN_FRAC;
  localparam int CW = $clog2(QB);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] DIVIDE  = 2'd2;
  localparam logic [1:0] PUBLISH = 2'd3;

  localparam logic [QB-1:0] DIVIDEND = {8'd255, {GAIN_FRAC{1'b0}}};

  logic [1:0]            state;
  logic                  fval_d;
  logic [DATA_WIDTH-1:0] acc_min;
  logic [DATA_WIDTH-1:0] acc_max;
  logic                  acc_hit;
  logic [DATA_WIDTH-1:0] wmin;
  logic [DATA_WIDTH-1:0] wmax;
  logic [DATA_WIDTH-1:0] span;
  logic [DATA_WIDTH:0]   rem;
  logic [QB-1:0]         dvd;
  logic [QB-1:0]         quo;
  logic [CW-1:0]         cnt;

  logic                  frame_end;
  logic [DATA_WIDTH-1:0] ld_min;
  logic [DATA_WIDTH-1:0] ld_max;
  logic [DATA_WIDTH-1:0] pub_min;
  logic [DATA_WIDTH-1:0] pub_max;
  logic [DATA_WIDTH-1:0] span_raw;
  logic [DATA_WIDTH-1:0] span_ld;
  logic [DATA_WIDTH:0]   trial;
  logic                  ge;

  assign frame_end = !fval_in && fval_d;
  assign busy      = (state != IDLE);

  // Statistics run continuously; a frame start with lval high counts as the first sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fval_d  <= 1'b0;
      acc_min <= '1;
      acc_max <= '0;
      acc_hit <= 1'b0;
    end else begin
      fval_d <= fval_in;
      if (fval_in && !fval_d) begin
        if (lval_in) begin
          acc_min <= data;
          acc_max <= data;
          acc_hit <= 1'b1;
        end else begin
          acc_min <= '1;
          acc_max <= '0;
          acc_hit <= 1'b0;
        end
      end else if (fval_in && lval_in) begin
        if (data < acc_min) acc_min <= data;
        if (data > acc_max) acc_max <= data;
        acc_hit <= 1'b1;
      end
    end
  end

`ifdef MINMAX_IIR_EN
  logic [DATA_WIDTH-1:0]        fmin;
  logic [DATA_WIDTH-1:0]        fmax;
  logic                         iir_first;
  logic signed [DATA_WIDTH:0]   dmin;
  logic signed [DATA_WIDTH:0]   dmax;
  logic signed [DATA_WIDTH:0]   dmin_sh;
  logic signed [DATA_WIDTH:0]   dmax_sh;

  // The step lies between the old filter value and the snapshot, so truncating it is exact.
  always_comb begin
    dmin    = $signed({1'b0, wmin}) - $signed({1'b0, fmin});
    dmax    = $signed({1'b0, wmax}) - $signed({1'b0, fmax});
    dmin_sh = dmin >>> IIR_SHIFT;
    dmax_sh = dmax >>> IIR_SHIFT;
    if (iir_first) begin
      ld_min = wmin;
      ld_max = wmax;
    end else begin
      ld_min = fmin + dmin_sh[DATA_WIDTH-1:0];
      ld_max = fmax + dmax_sh[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fmin      <= '0;
      fmax      <= '0;
      iir_first <= 1'b1;
    end else if (state == LOAD) begin
      fmin      <= ld_min;
      fmax      <= ld_max;
      iir_first <= 1'b0;
    end
  end

  assign pub_min = fmin;
  assign pub_max = fmax;
`else
  assign ld_min  = wmin;
  assign ld_max  = wmax;
  assign pub_min = wmin;
  assign pub_max = wmax;
`endif

  assign span_raw = ld_max - ld_min;
  assign span_ld  = (span_raw == '0) ? {{(DATA_WIDTH-1){1'b0}}, 1'b1} : span_raw;
  assign trial    = {rem[DATA_WIDTH-1:0], dvd[QB-1]};
  assign ge       = (trial >= {1'b0, span});

  // Restoring divider: one quotient bit per DIVIDE cycle, outputs only move in PUBLISH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wmin      <= '0;
      wmax      <= '0;
      span      <= '0;
      rem       <= '0;
      dvd       <= '0;
      quo       <= '0;
      cnt       <= '0;
      min_val   <= '0;
      max_val   <= '1;
      gain      <= '0;
      cfg_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      cfg_valid <= 1'b0;
      if (frame_end && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_end && en && acc_hit) begin
            wmin  <= acc_min;
            wmax  <= acc_max;
            state <= LOAD;
          end
        end
        LOAD: begin
          span  <= span_ld;
          rem   <= '0;
          dvd   <= DIVIDEND;
          quo   <= '0;
          cnt   <= CW'(QB - 1);
          state <= DIVIDE;
        end
        DIVIDE: begin
          rem <= ge ? (trial - {1'b0, span}) : trial;
          quo <= {quo[QB-2:0], ge};
          dvd <= {dvd[QB-2:0], 1'b0};
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= PUBLISH;
        end
        PUBLISH: begin
          min_val   <= pub_min;
          max_val   <= pub_max;
          gain      <= quo;
          cfg_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
